pwm_ctrl: RTL
=============

# pwm_ctrl

Sequencing controller for the PWM datapath. It owns the period counter, double-buffers period/duty settings so updates apply only on a period boundary, and drives the registered PWM output flop. It runs a start/run/drain state machine so enabling and disabling never produce a truncated period or a glitch.

## Interface
- `WIDTH`, default 8: width of counter, period and duty.
- `ck`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run request; level-sensitive.
- `period`  in  WIDTH  requested period minus one; a period lasts `period+1` cycles.
- `duty`  in  WIDTH  requested high-time in cycles.
- `load`  in  1  single-cycle strobe; captures `period`/`duty` into the pending register.
- `busy`  out  1  pending register holds values not yet applied.
- `ack`  out  1  one-cycle pulse; pending values were transferred to the active registers.
- `cycle_end`  out  1  one-cycle pulse on the last count of each period.
- `pwm`  out  1  registered PWM output.

## Operation
- Registers:
  - `cnt`.
  - Active pair `period_a`/`duty_a`.
  - Pending pair `period_p`/`duty_p`.
  - `busy`, state.
- Reset values:
  - `cnt`=0, `period_a`=2^WIDTH-1, `duty_a`=0, pending=0.
  - `busy`=0, `ack`=0, `cycle_end`=0, `pwm`=0, state IDLE.
  - Reset mid-operation discards pending values and forces IDLE on the next edge.
- Load:
  - `load`=1 captures inputs into pending and sets `busy`.
  - `load` while `busy` overwrites pending; `busy` stays 1 and only one `ack` follows.
- Transfer pending→active happens when `busy`=1 and either:
  - the state is IDLE, or
  - the state is RUN/DRAIN and `cnt`==`period_a`.
- On a transfer edge: `busy`→0 and `ack`=1 for the next cycle.
  - Exception: if `load`=1 on that same edge, the transfer uses the old pending values, the new values are captured, and `busy` stays 1.
- States:
  - IDLE: `cnt` held at 0 and `pwm`=0. `en`=1 → RUN.
  - RUN: `cnt` increments and wraps to 0 after `period_a`. `en`=0 → DRAIN.
  - DRAIN: counts like RUN. At wrap → IDLE. `en`=1 before wrap → RUN with no interruption.
- Counting and wrap:
  - `cycle_end` is registered; it is high for the cycle after the edge where `cnt`==`period_a` in RUN/DRAIN.
  - `cnt` compares and wraps against the new `period_a` from the cycle after a transfer.
- Output: next `pwm` = (state≠IDLE) & (`cnt` < `duty_a`), with an unsigned WIDTH-bit compare.
  - `duty_a`=0 → constant 0.
  - `duty_a` > `period_a` → constant 1 while running (100%).
  - `period_a`=0 → 1-cycle periods; `pwm` = (`duty_a`≠0).

## Timing
- `en` sampled high at edge E0 → RUN with `cnt`=0 after E0 → first `pwm` high in the cycle after E1. Latency is 2 cycles.
- High time per period is exactly min(`duty_a`, `period_a`+1) cycles, contiguous, and starts at the first count of each period.
- `load` at edge E in IDLE → active registers updated at E+1, `ack` high during the cycle after E+1.
- A `load` in RUN takes effect at the first wrap after capture. A period is never truncated or extended.
- `en` dropped mid-period: the current period completes in full, then `pwm`=0 and IDLE.

## Structure
- Package `pwm_pkg`:
  - State enum `pwm_state_t` {IDLE, RUN, DRAIN}.
  - Default `WIDTH` constant.
- Sub-module `pwm_reg`: single-bit D flop with synchronous active-high reset, used for `pwm`, `ack` and `cycle_end`.

## Test plan
- Reset, then `load` period=9/duty=3 in IDLE and `en`=1 → `ack` one cycle; `pwm` pattern 3 high / 7 low repeating; `cycle_end` every 10 cycles.
- Running at 9/3, `load` 4/5 mid-period → `busy`=1 until wrap; current 10-cycle period completes, then periods of 5 cycles all high (duty>period); `ack` pulses once.
- Two `load`s before a wrap (2/1, then 7/7) → one `ack`; 7/7 applied (7 high, 1 low); 2/1 never seen.
- `en`=0 at count 4 of period 9 → counting continues through `cnt`=9, then IDLE, `pwm`=0; `en` re-asserted at count 6 → no gap, stays RUN.
- duty=0 and period=0 cases → `pwm` constant 0; then period=0/duty=1 → `pwm` constant 1 and `cycle_end` every cycle.
- `rst` asserted mid-period with `busy`=1 → next cycle all outputs 0, `busy`=0, pending discarded, state IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM sequencing controller.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_reg.sv
// Single-bit D flop with synchronous active-high reset; used for every registered output.
module pwm_reg (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge ck) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/pwm_ctrl.sv
// PWM period counter with double-buffered period/duty and an IDLE/RUN/DRAIN sequencer
// so enabling, disabling and setting changes only ever take effect on a period boundary.
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             busy,
  output logic             ack,
  output logic             cycle_end,
  output logic             pwm,
  output logic [1:0]       state_dbg
);

  // Handshake: load is a one-cycle strobe with no back-pressure; every load is captured.
  // busy stays high while captured values await a boundary, and ack pulses for one
  // cycle after each transfer of pending values into the active pair.

  pwm_state_t       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_a, duty_a;
  logic [WIDTH-1:0] period_p, duty_p;
  logic             busy_q;
  logic             active;
  logic             at_end;
  logic             xfer;
  logic             pwm_d;

  assign active = (state != IDLE);
  assign at_end = active && (cnt == period_a);
  // In IDLE there is no period in flight, so pending values may apply immediately.
  assign xfer   = busy_q && (!active || (cnt == period_a));
  assign pwm_d  = active && (cnt < duty_a);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) state_nxt = at_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (en)          state_nxt = RUN;
        else if (at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (active && !at_end) cnt_nxt = cnt + WIDTH'(1);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_a <= '1;
      duty_a   <= '0;
      period_p <= '0;
      duty_p   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (xfer) begin
        period_a <= period_p;
        duty_a   <= duty_p;
      end
      // A load coinciding with a transfer moves the old pending pair and keeps the new one.
      if (load) begin
        period_p <= period;
        duty_p   <= duty;
        busy_q   <= 1'b1;
      end else if (xfer) begin
        busy_q <= 1'b0;
      end
    end
  end

  pwm_reg u_pwm_reg (.ck(ck), .rst(rst), .d(pwm_d),  .q(pwm));
  pwm_reg u_ack_reg (.ck(ck), .rst(rst), .d(xfer),   .q(ack));
  pwm_reg u_end_reg (.ck(ck), .rst(rst), .d(at_end), .q(cycle_end));

  assign busy      = busy_q;
  assign state_dbg = state;

endmodule
